// File: rtl/li_pkg.sv
// Shared helpers for the latency-insensitive FIFO: width/depth arithmetic and
// elaboration-time diagnostics.
package li_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

   // A width of 0 is a pure token FIFO that still carries a 1-bit dummy lane.
   function automatic int eff_w(input int width);
      return (width < 1) ? 1 : width;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   localparam string DEPTH_MSG = "li_fifo: depth must be >= 2 and a power of 2";

endpackage

// File: rtl/li_fifo_mem.sv
// Simple dual-port storage for li_fifo: synchronous write, asynchronous read.
module li_fifo_mem #(
   parameter int W  = 1,
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic          CLK,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [N];

   always_ff @(posedge CLK) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/li_fifo.sv
// Latency-insensitive FIFO with VALID/CONSUMED token handshake; bubbles pass
// through without storage. Optional same-cycle bypass: LI_FIFO_BYPASS_EN.
module li_fifo
   import li_pkg::*;
#(
   parameter int width = 1,
   parameter int depth = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [eff_w(width)-1:0]       IN_ENQ,
   input  logic                          IN_ENQ_VALID,
   output logic                          IN_ENQ_CONSUMED,
   input  logic                          IN_EN_ENQ,
   input  logic                          IN_EN_ENQ_VALID,
   output logic                          IN_EN_ENQ_CONSUMED,
   output logic [eff_w(width)-1:0]       OUT_FIRST,
   output logic                          OUT_FIRST_VALID,
   input  logic                          OUT_FIRST_CONSUMED,
   output logic [clog2(depth+1)-1:0]     OUT_COUNT
);

   localparam int EW = eff_w(width);
   localparam int PW = clog2(depth);
   localparam int CW = clog2(depth + 1);

   if (!depth_ok(depth)) begin : g_bad_depth
      $error(DEPTH_MSG);
   end

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inp_valid, accept, push, pop, wr_en, not_empty;
   logic [EW-1:0] mem_rdata;

   assign not_empty = (count_q != '0);
   assign inp_valid = ((width == 0) ? 1'b1 : IN_ENQ_VALID) && IN_EN_ENQ_VALID;
   // Acceptance depends only on state, never on the downstream pop.
   assign accept    = inp_valid && (!IN_EN_ENQ || (count_q != CW'(depth)));
   assign push      = accept && IN_EN_ENQ;

   assign IN_ENQ_CONSUMED    = accept;
   assign IN_EN_ENQ_CONSUMED = accept;
   assign OUT_COUNT          = count_q;

`ifdef LI_FIFO_BYPASS_EN
   logic bypass_vis;
   assign bypass_vis      = !not_empty && push;
   assign OUT_FIRST_VALID = not_empty || bypass_vis;
   assign OUT_FIRST       = bypass_vis ? IN_ENQ : mem_rdata;
   assign pop             = not_empty && OUT_FIRST_CONSUMED;
   // A bypassed entry taken in the same cycle never touches storage.
   assign wr_en           = push && !(bypass_vis && OUT_FIRST_CONSUMED);
`else
   assign OUT_FIRST_VALID = not_empty;
   assign OUT_FIRST       = mem_rdata;
   assign pop             = not_empty && OUT_FIRST_CONSUMED;
   assign wr_en           = push;
`endif

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   li_fifo_mem #(
      .W  (EW),
      .N  (depth),
      .AW (PW)
   ) u_mem (
      .CLK     (CLK),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (IN_ENQ),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

endmodule
